slot_round_ctrl: RTL and testbench

SLOT_ROUND_CTRL -- requirements
Module: slot_round_ctrl

---
 rtl/slot_round_ctrl_pkg.sv | 23 ++
 rtl/edge_det.sv | 24 ++
 rtl/slot_round_ctrl.sv | 158 +++++++++++++++
 tb/tb_slot_round_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_round_ctrl_pkg.sv
// Shared definitions for the slot machine round controller:
// state encoding, slot count, credit width and default parameter values.
package slot_round_ctrl_pkg;

    localparam int unsigned NUM_SLOTS      = 9;
    localparam int unsigned CREDIT_W       = 3;
    localparam int unsigned WIN_W          = 3;
    localparam int unsigned CREDIT_MAX_DEF = 7;
    localparam int unsigned PAY_GAP_DEF    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SPIN = 2'd1,
        ST_EVAL = 2'd2,
        ST_PAY  = 2'd3
    } state_t;

    // Isolates the lowest set bit (one-hot, or zero if none set).
    function automatic logic [NUM_SLOTS-1:0] lowest_one(input logic [NUM_SLOTS-1:0] v);
        return v & (~v + NUM_SLOTS'(1));
    endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector, W bits wide.
// Ports: clk, clrb (async active-low), sig (level input), rise_c (comb, high
// for the cycle in which sig is seen high after being low).
// History resets to all ones so an input held high through reset gives no edge.
module edge_det #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         clrb,
    input  logic [W-1:0] sig,
    output logic [W-1:0] rise_c
);

    logic [W-1:0] prev;

    // Previous-cycle sample of the input.
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) prev <= '1;
        else       prev <= sig;
    end

    assign rise_c = sig & ~prev;

endmodule

// File: rtl/slot_round_ctrl.sv
// Slot machine round controller: takes coins into a saturating credit
// counter, runs a spin round (9 slots stopped by buttons, serviced lowest
// index first), requests a win evaluation and pays out coins one at a time.
// Ports:
//   clk, clrb          clock, async active-low reset
//   coin_in            coin sensor level (one coin per rising edge)
//   btn[8:0]           stop buttons, one stop per rising edge
//   win_vld, win_cnt   evaluator result pulse and coins to pay
//   spin_en[8:0]       slot i spinning
//   stop_pulse[8:0]    one-hot, slot i latches its symbol this cycle
//   eval_req           single-cycle evaluation request
//   coin_out           single-cycle payout pulse
//   credit             unplayed coins
//   busy               not IDLE
module slot_round_ctrl
    import slot_round_ctrl_pkg::*;
#(
    parameter int unsigned CREDIT_MAX = CREDIT_MAX_DEF,
    parameter int unsigned PAY_GAP    = PAY_GAP_DEF
) (
    input  logic                 clk,
    input  logic                 clrb,
    input  logic                 coin_in,
    input  logic [NUM_SLOTS-1:0] btn,
    input  logic                 win_vld,
    input  logic [WIN_W-1:0]     win_cnt,
    output logic [NUM_SLOTS-1:0] spin_en,
    output logic [NUM_SLOTS-1:0] stop_pulse,
    output logic                 eval_req,
    output logic                 coin_out,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 busy
);

    localparam int unsigned GAP_W = (PAY_GAP < 2) ? 1 : $clog2(PAY_GAP + 1);

    state_t               state;
    logic [NUM_SLOTS-1:0] pending;
    logic [WIN_W-1:0]     pay_cnt;
    logic [GAP_W-1:0]     gap_cnt;

    logic                 coin_rise_c;
    logic [NUM_SLOTS-1:0] btn_rise_c;
    logic                 start_c;
    logic [NUM_SLOTS-1:0] svc_c;
    logic [NUM_SLOTS-1:0] new_pend_c;

    edge_det #(.W(1)) u_coin_edge (
        .clk    (clk),
        .clrb   (clrb),
        .sig    (coin_in),
        .rise_c (coin_rise_c)
    );

    edge_det #(.W(NUM_SLOTS)) u_btn_edge (
        .clk    (clk),
        .clrb   (clrb),
        .sig    (btn),
        .rise_c (btn_rise_c)
    );

    // Round start, arbiter pick, and new stop requests for still-spinning slots
    // (a slot being serviced this cycle cannot be re-armed).
    always_comb begin
        start_c    = 1'b0;
        svc_c      = '0;
        new_pend_c = '0;
        start_c    = (state == ST_IDLE) && (credit != '0);
        svc_c      = lowest_one(pending);
        new_pend_c = btn_rise_c & spin_en & ~svc_c;
    end

    // Credit counter: a coin arriving on a start edge cancels the decrement.
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            credit <= '0;
        end else if (start_c && !coin_rise_c) begin
            credit <= credit - CREDIT_W'(1);
        end else if (!start_c && coin_rise_c && (credit != CREDIT_W'(CREDIT_MAX))) begin
            credit <= credit + CREDIT_W'(1);
        end
    end

    // Round FSM with registered outputs, stop arbiter and payout timer.
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            state      <= ST_IDLE;
            spin_en    <= '0;
            stop_pulse <= '0;
            pending    <= '0;
            eval_req   <= 1'b0;
            coin_out   <= 1'b0;
            busy       <= 1'b0;
            pay_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            stop_pulse <= '0;
            eval_req   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        state   <= ST_SPIN;
                        spin_en <= '1;
                        pending <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_SPIN: begin
                    if (spin_en == '0) begin
                        state    <= ST_EVAL;
                        eval_req <= 1'b1;
                    end else begin
                        stop_pulse <= svc_c;
                        spin_en    <= spin_en & ~svc_c;
                        pending    <= (pending & ~svc_c) | new_pend_c;
                    end
                end
                ST_EVAL: begin
                    if (win_vld) begin
                        if (win_cnt == '0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ST_PAY;
                            coin_out <= 1'b1;
                            pay_cnt  <= win_cnt - WIN_W'(1);
                        end
                    end
                end
                ST_PAY: begin
                    // pay_cnt holds pulses still owed after the current one.
                    if (coin_out) begin
                        if (pay_cnt == '0) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            coin_out <= 1'b0;
                        end else if (PAY_GAP == 0) begin
                            pay_cnt <= pay_cnt - WIN_W'(1);
                        end else begin
                            coin_out <= 1'b0;
                            gap_cnt  <= GAP_W'(PAY_GAP - 1);
                        end
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end else begin
                        coin_out <= 1'b1;
                        pay_cnt  <= pay_cnt - WIN_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slot_round_ctrl.sv
// Bench for slot_round_ctrl: scenario tasks with scoreboard queues of
// expected stop pulses and payout patterns.
module tb_slot_round_ctrl;
    import slot_round_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       clrb;
    logic       coin_in;
    logic [8:0] btn;
    logic       win_vld;
    logic [2:0] win_cnt;
    logic [8:0] spin_en;
    logic [8:0] stop_pulse;
    logic       eval_req;
    logic       coin_out;
    logic [2:0] credit;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_stop_q[$];
    logic       exp_coin_q[$];

    always #5 clk = ~clk;

    slot_round_ctrl #(.CREDIT_MAX(7), .PAY_GAP(2)) dut (
        .clk        (clk),
        .clrb       (clrb),
        .coin_in    (coin_in),
        .btn        (btn),
        .win_vld    (win_vld),
        .win_cnt    (win_cnt),
        .spin_en    (spin_en),
        .stop_pulse (stop_pulse),
        .eval_req   (eval_req),
        .coin_out   (coin_out),
        .credit     (credit),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clrb = 1'b0; coin_in = 1'b0; btn = '0; win_vld = 1'b0; win_cnt = '0;
        tick(); tick();
        n_checks++;
        if ({spin_en, stop_pulse, eval_req, coin_out, busy} !== 21'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0", {spin_en, stop_pulse, eval_req, coin_out, busy});
        end
        n_checks++;
        if (credit !== 3'd0) begin n_fail++; $display("FAIL reset_credit: got %0d required 0", credit); end
        clrb = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_start();
        coin_in = 1'b1;
        tick();
        n_checks++;
        if (credit !== 3'd1) begin n_fail++; $display("FAIL coin_credit: got %0d required 1", credit); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL coin_idle_busy: got %b required 0", busy); end
        coin_in = 1'b0;
        tick();
        n_checks++;
        if (credit !== 3'd0) begin n_fail++; $display("FAIL start_credit: got %0d required 0", credit); end
        n_checks++;
        if (spin_en !== 9'h1FF) begin n_fail++; $display("FAIL start_spin_en: got %h required 1ff", spin_en); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b required 1", busy); end
    endtask

    task automatic test_multi_stop();
        logic [8:0] exp;
        btn = 9'h00E;
        tick();
        btn = '0;
        n_checks++;
        if (stop_pulse !== 9'h000) begin n_fail++; $display("FAIL multi_stop_early: got %h required 000", stop_pulse); end
        exp_stop_q.push_back(9'h002);
        exp_stop_q.push_back(9'h004);
        exp_stop_q.push_back(9'h008);
        for (int k = 0; k < 3; k++) begin
            tick();
            exp = (exp_stop_q.size() != 0) ? exp_stop_q.pop_front() : 9'h000;
            n_checks++;
            if (stop_pulse !== exp) begin n_fail++; $display("FAIL multi_stop_%0d: got %h required %h", k, stop_pulse, exp); end
        end
        n_checks++;
        if (spin_en !== 9'h1F1) begin n_fail++; $display("FAIL multi_stop_spin_en: got %h required 1f1", spin_en); end
    endtask

    task automatic test_saturate();
        logic [2:0] exp;
        for (int n = 1; n <= 8; n++) begin
            coin_in = 1'b1;
            tick();
            coin_in = 1'b0;
            tick();
            exp = (n > 7) ? 3'd7 : 3'(n);
            n_checks++;
            if (credit !== exp) begin n_fail++; $display("FAIL saturate_%0d: got %0d required %0d", n, credit, exp); end
        end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL saturate_busy: got %b required 1", busy); end
    endtask

    task automatic test_finish_round();
        logic [8:0] exp;
        // slot 2 already stopped; its press must be ignored
        btn = 9'h1F5;
        tick();
        btn = '0;
        exp_stop_q.push_back(9'h001);
        exp_stop_q.push_back(9'h010);
        exp_stop_q.push_back(9'h020);
        exp_stop_q.push_back(9'h040);
        exp_stop_q.push_back(9'h080);
        exp_stop_q.push_back(9'h100);
        for (int k = 0; k < 6; k++) begin
            tick();
            exp = (exp_stop_q.size() != 0) ? exp_stop_q.pop_front() : 9'h000;
            n_checks++;
            if (stop_pulse !== exp) begin n_fail++; $display("FAIL finish_stop_%0d: got %h required %h", k, stop_pulse, exp); end
        end
        tick();
        n_checks++;
        if (eval_req !== 1'b1) begin n_fail++; $display("FAIL finish_eval_req: got %b required 1", eval_req); end
        n_checks++;
        if (stop_pulse !== 9'h000) begin n_fail++; $display("FAIL finish_extra_stop: got %h required 000", stop_pulse); end
        tick();
        n_checks++;
        if (eval_req !== 1'b0) begin n_fail++; $display("FAIL finish_eval_req_len: got %b required 0", eval_req); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({busy, coin_out} !== 2'b10) begin n_fail++; $display("FAIL eval_wait_%0d: got busy,coin %b required 10", k, {busy, coin_out}); end
        end
        win_vld = 1'b1; win_cnt = 3'd0;
        tick();
        win_vld = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_win_idle: got busy %b required 0", busy); end
        // coin edge on the start edge leaves credit unchanged
        coin_in = 1'b1;
        tick();
        coin_in = 1'b0;
        n_checks++;
        if (credit !== 3'd7) begin n_fail++; $display("FAIL start_coin_credit: got %0d required 7", credit); end
        n_checks++;
        if ({busy, spin_en} !== 10'h3FF) begin n_fail++; $display("FAIL restart_spin: got %h required 3ff", {busy, spin_en}); end
    endtask

    task automatic test_all_stops();
        logic [8:0] btn_seq[$];
        logic [8:0] push_seq[$];
        logic [8:0] exp;
        int         n_pulses;
        logic       early_eval;
        n_pulses   = 0;
        early_eval = 1'b0;
        // btn8: raise, hold, drop, re-raise (already stopped), drop
        btn_seq.push_back(9'h100); push_seq.push_back(9'h100);
        btn_seq.push_back(9'h100); push_seq.push_back(9'h000);
        btn_seq.push_back(9'h100); push_seq.push_back(9'h000);
        btn_seq.push_back(9'h000); push_seq.push_back(9'h000);
        btn_seq.push_back(9'h100); push_seq.push_back(9'h000);
        btn_seq.push_back(9'h000); push_seq.push_back(9'h000);
        for (int i = 0; i < 8; i++) begin
            btn_seq.push_back(9'(1 << i)); push_seq.push_back(9'(1 << i));
            btn_seq.push_back(9'h000);     push_seq.push_back(9'h000);
        end
        for (int j = 0; j < btn_seq.size(); j++) begin
            btn = btn_seq[j];
            // a win result outside EVAL must be ignored
            win_vld = (j == 0); win_cnt = 3'd5;
            if (push_seq[j] != 9'h000) exp_stop_q.push_back(push_seq[j]);
            tick();
            if (eval_req !== 1'b0) early_eval = 1'b1;
            if (stop_pulse !== 9'h000) begin
                n_pulses++;
                exp = (exp_stop_q.size() != 0) ? exp_stop_q.pop_front() : 9'h000;
                n_checks++;
                if (stop_pulse !== exp) begin n_fail++; $display("FAIL all_stop_step%0d: got %h required %h", j, stop_pulse, exp); end
            end
        end
        win_vld = 1'b0; win_cnt = '0; btn = '0;
        n_checks++;
        if (n_pulses != 9) begin n_fail++; $display("FAIL all_stop_count: got %0d required 9", n_pulses); end
        n_checks++;
        if (exp_stop_q.size() != 0) begin n_fail++; $display("FAIL all_stop_missing: got %0d left required 0", exp_stop_q.size()); end
        n_checks++;
        if (early_eval !== 1'b0) begin n_fail++; $display("FAIL all_stop_early_eval: got %b required 0", early_eval); end
        tick();
        n_checks++;
        if (eval_req !== 1'b1) begin n_fail++; $display("FAIL all_stop_eval_req: got %b required 1", eval_req); end
        tick();
        n_checks++;
        if (eval_req !== 1'b0) begin n_fail++; $display("FAIL all_stop_eval_len: got %b required 0", eval_req); end
    endtask

    task automatic test_pay();
        logic exp;
        tick();
        n_checks++;
        if (coin_out !== 1'b0) begin n_fail++; $display("FAIL pay_before_win: got %b required 0", coin_out); end
        win_vld = 1'b1; win_cnt = 3'd3;
        exp_coin_q.push_back(1'b1); exp_coin_q.push_back(1'b0); exp_coin_q.push_back(1'b0);
        exp_coin_q.push_back(1'b1); exp_coin_q.push_back(1'b0); exp_coin_q.push_back(1'b0);
        exp_coin_q.push_back(1'b1);
        tick();
        win_vld = 1'b0; win_cnt = '0;
        for (int k = 0; k < 7; k++) begin
            exp = (exp_coin_q.size() != 0) ? exp_coin_q.pop_front() : 1'b0;
            n_checks++;
            if (coin_out !== exp) begin n_fail++; $display("FAIL pay_pattern_%0d: got %b required %b", k, coin_out, exp); end
            tick();
        end
        n_checks++;
        if ({busy, coin_out} !== 2'b00) begin n_fail++; $display("FAIL pay_end_idle: got busy,coin %b required 00", {busy, coin_out}); end
        n_checks++;
        if (credit !== 3'd7) begin n_fail++; $display("FAIL pay_end_credit: got %0d required 7", credit); end
        tick();
        n_checks++;
        if ({busy, spin_en} !== 10'h3FF) begin n_fail++; $display("FAIL auto_restart: got %h required 3ff", {busy, spin_en}); end
        n_checks++;
        if (credit !== 3'd6) begin n_fail++; $display("FAIL auto_restart_credit: got %0d required 6", credit); end
    endtask

    task automatic test_reset_mid_pay();
        logic [8:0] exp;
        btn = 9'h1FF;
        tick();
        btn = '0;
        for (int i = 0; i < 9; i++) exp_stop_q.push_back(9'(1 << i));
        for (int k = 0; k < 9; k++) begin
            tick();
            exp = (exp_stop_q.size() != 0) ? exp_stop_q.pop_front() : 9'h000;
            n_checks++;
            if (stop_pulse !== exp) begin n_fail++; $display("FAIL burst_stop_%0d: got %h required %h", k, stop_pulse, exp); end
        end
        tick();
        n_checks++;
        if (eval_req !== 1'b1) begin n_fail++; $display("FAIL burst_eval_req: got %b required 1", eval_req); end
        win_vld = 1'b1; win_cnt = 3'd5;
        tick();
        win_vld = 1'b0; win_cnt = '0;
        n_checks++;
        if (coin_out !== 1'b1) begin n_fail++; $display("FAIL mid_pay_first: got %b required 1", coin_out); end
        tick(); tick();
        btn = 9'h1FF; coin_in = 1'b1; clrb = 1'b0;
        #1;
        n_checks++;
        if ({spin_en, stop_pulse, eval_req, coin_out, busy} !== 21'h0) begin
            n_fail++; $display("FAIL mid_pay_reset_outputs: got %h required 0", {spin_en, stop_pulse, eval_req, coin_out, busy});
        end
        n_checks++;
        if (credit !== 3'd0) begin n_fail++; $display("FAIL mid_pay_reset_credit: got %0d required 0", credit); end
        tick(); tick();
        clrb = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({stop_pulse, spin_en, busy, credit} !== 22'h0) begin
                n_fail++; $display("FAIL held_after_reset_%0d: got %h required 0", k, {stop_pulse, spin_en, busy, credit});
            end
        end
        btn = '0; coin_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_multi_stop();
        test_saturate();
        test_finish_round();
        test_all_stops();
        test_pay();
        test_reset_mid_pay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
